// File: rtl/gcd_unit_if.sv
// gcd_unit_if: host-side bus of the GCD engine.
//   req     - host request; loadVal carries a valid operand while high
//   ack     - four-phase acknowledge from the engine
//   loadVal - operand data (WIDTH bits)
//   result  - last GCD published by the engine (WIDTH bits)
// master: the host / stimulus agent.  slave: the GCD engine.
interface gcd_unit_if #(
  parameter int WIDTH = 16
);
  logic             req;
  logic             ack;
  logic [WIDTH-1:0] loadVal;
  logic [WIDTH-1:0] result;

  modport master (
    output req,
    output loadVal,
    input  ack,
    input  result
  );

  modport slave (
    input  req,
    input  loadVal,
    output ack,
    output result
  );
endinterface

// File: rtl/gcd_unit.sv
// gcd_unit: sequential subtractive-Euclid GCD engine for unsigned operands.
// Operand A then operand B are taken over a four-phase req/ack handshake on
// a shared data bus; the engine then performs one Euclid step per cycle and
// publishes the GCD on result, which holds until the next completion.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous, active-high
//   bus   - gcd_unit_if slave modport (req, ack, loadVal, result)
module gcd_unit #(
  parameter int WIDTH = 16
) (
  input  logic     clock,
  input  logic     reset,
  gcd_unit_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_A,
    ACK_A,
    WAIT_B,
    ACK_B,
    COMPUTE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] result_q, result_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ack_d    = ack_q;
    result_d = result_q;
    case (state_q)
      WAIT_A: begin
        if (bus.req) begin
          a_d     = bus.loadVal;
          ack_d   = 1'b1;
          state_d = ACK_A;
        end
      end
      ACK_A: begin
        if (!bus.req) begin
          ack_d   = 1'b0;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.req) begin
          b_d     = bus.loadVal;
          ack_d   = 1'b1;
          state_d = ACK_B;
        end
      end
      ACK_B: begin
        if (!bus.req) begin
          ack_d   = 1'b0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        // Zero operands terminate immediately so gcd(0,x)=x and gcd(0,0)=0;
        // only the larger operand is reduced, so subtraction never wraps.
        if (a_q == '0) begin
          result_d = b_q;
          state_d  = WAIT_A;
        end else if (b_q == '0) begin
          result_d = a_q;
          state_d  = WAIT_A;
        end else if (a_q == b_q) begin
          result_d = a_q;
          state_d  = WAIT_A;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      default: begin
        state_d = WAIT_A;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_A;
      a_q      <= '0;
      b_q      <= '0;
      ack_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ack_q    <= ack_d;
      result_q <= result_d;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: directed bench for gcd_unit. Inputs change on the falling
// edge, outputs are sampled on the falling edge (or #1 after an async reset).
module tb_gcd_unit;

  localparam int WIDTH = 16;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [WIDTH-1:0] exp_result;

  gcd_unit_if #(.WIDTH(WIDTH)) bus ();

  gcd_unit #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full four-phase transfer, entered and left on a falling edge.
  task automatic send_op(input logic [WIDTH-1:0] val, input string tag);
    bus.req     = 1'b1;
    bus.loadVal = val;
    @(negedge clock);
    check({tag, " ack rise"}, {31'd0, bus.ack}, 32'd1);
    check({tag, " result held"}, {16'd0, bus.result}, {16'd0, exp_result});
    bus.req     = 1'b0;
    bus.loadVal = WIDTH'($urandom);
    @(negedge clock);
    check({tag, " ack fall"}, {31'd0, bus.ack}, 32'd0);
  endtask

  // Called right after B's handshake: the result must stay put for cyc-1
  // cycles and show the new GCD on cycle cyc.
  task automatic wait_result(input logic [WIDTH-1:0] exp, input int cyc, input string tag);
    repeat (cyc - 1) @(negedge clock);
    check({tag, " before done"}, {16'd0, bus.result}, {16'd0, exp_result});
    @(negedge clock);
    check({tag, " result"}, {16'd0, bus.result}, {16'd0, exp});
    exp_result = exp;
    $display("pair %s: result=%h expected=%h after %0d cycles", tag, bus.result, exp, cyc);
  endtask

  task automatic run_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp, input int cyc, input string tag);
    send_op(a, {tag, " A"});
    send_op(b, {tag, " B"});
    wait_result(exp, cyc, tag);
  endtask

  initial begin
    int ack_seen;
    checks      = 0;
    errors      = 0;
    exp_result  = '0;
    reset       = 1'b0;
    bus.req     = 1'b0;
    bus.loadVal = '0;

    // Asynchronous reset before any clock edge.
    #3 reset = 1'b1;
    #1;
    check("reset ack", {31'd0, bus.ack}, 32'd0);
    check("reset result", {16'd0, bus.result}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    ack_seen = 0;
    repeat (5) begin
      @(negedge clock);
      if (bus.ack !== 1'b0) ack_seen++;
    end
    check("idle ack", ack_seen, 0);

    // Main case: 27 subtractions + 1.
    run_pair(16'h4444, 16'h700C, 16'h0004, 28, "4444_700C");
    run_pair(16'd12, 16'd12, 16'd12, 1, "12_12");
    run_pair(16'd0, 16'd9, 16'd9, 1, "0_9");
    run_pair(16'd9, 16'd0, 16'd9, 1, "9_0");
    run_pair(16'd0, 16'd0, 16'd0, 1, "0_0");

    // Long req: ack stays high, A latched once, later loadVal ignored.
    bus.req     = 1'b1;
    bus.loadVal = 16'd12;
    ack_seen    = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.ack === 1'b1) ack_seen++;
      if (i == 2) bus.loadVal = 16'd99;
    end
    check("long req ack high", ack_seen, 6);
    bus.req = 1'b0;
    @(negedge clock);
    check("long req ack fall", {31'd0, bus.ack}, 32'd0);
    send_op(16'd8, "12_8 B");
    wait_result(16'd4, 3, "12_8");

    // Worst case (0xFFFF,1): 65534 subtractions + 1, with req raised mid-compute.
    send_op(16'hFFFF, "FFFF_1 A");
    send_op(16'h0001, "FFFF_1 B");
    @(negedge clock);
    bus.req     = 1'b1;
    bus.loadVal = 16'd48;
    ack_seen    = 0;
    for (int i = 2; i <= 65535; i++) begin
      @(negedge clock);
      if (bus.ack !== 1'b0) ack_seen++;
    end
    check("compute req no ack", ack_seen, 0);
    check("FFFF_1 result", {16'd0, bus.result}, 32'd1);
    $display("pair FFFF_1: result=%h expected=0001 after 65535 cycles", bus.result);
    exp_result = 16'd1;
    @(negedge clock);
    check("queued req ack", {31'd0, bus.ack}, 32'd1);
    bus.req = 1'b0;
    @(negedge clock);
    check("queued req ack fall", {31'd0, bus.ack}, 32'd0);
    send_op(16'd18, "48_18q B");
    wait_result(16'd6, 5, "48_18q");

    // Reset while in ACK_B.
    send_op(16'd48, "rst A");
    bus.req     = 1'b1;
    bus.loadVal = 16'd18;
    @(negedge clock);
    check("ACK_B ack", {31'd0, bus.ack}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ACK_B reset ack", {31'd0, bus.ack}, 32'd0);
    check("ACK_B reset result", {16'd0, bus.result}, 32'd0);
    bus.req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_result = '0;

    // Reset mid-compute of the mirrored worst case (1,0xFFFF).
    send_op(16'h0001, "1_FFFF A");
    send_op(16'hFFFF, "1_FFFF B");
    repeat (100) @(negedge clock);
    check("mid compute result", {16'd0, bus.result}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("mid compute reset ack", {31'd0, bus.ack}, 32'd0);
    check("mid compute reset result", {16'd0, bus.result}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_pair(16'd48, 16'd18, 16'd6, 5, "48_18");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
